// File: rtl/n_mem_arbiter.sv
// Serializes a warp-wide memory request from N SP lanes onto one single-ported
// synchronous memory, one access per cycle in lane order, and pulses MReady when done.
module n_mem_arbiter #(
    parameter int N_CORES = 8,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MRead,
    input  logic                    MWrite,
    input  logic [N_CORES-1:0]      en,
    input  logic [N_CORES*AW-1:0]   addr,
    input  logic [N_CORES*DW-1:0]   data,
    output logic [N_CORES*DW-1:0]   q,
    output logic                    MReady,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    input  logic [DW-1:0]           mem_rdata
);

    localparam int LW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    req_prev_q, req_prev_d;
    logic                    wr_q, wr_d;
    logic [N_CORES-1:0]      pend_q, pend_d;
    logic [N_CORES*AW-1:0]   addr_snap_q, addr_snap_d;
    logic [N_CORES*DW-1:0]   data_snap_q, data_snap_d;
    logic                    rd_vld_q, rd_vld_d;
    logic [LW-1:0]           rd_lane_q, rd_lane_d;
    logic [N_CORES*DW-1:0]   q_q, q_d;

    logic [AW-1:0]           snap_addr_a [N_CORES];
    logic [DW-1:0]           snap_data_a [N_CORES];
    logic [LW-1:0]           lane_sel;
    logic [N_CORES-1:0]      pend_clr;
    logic                    start;

    genvar gi;
    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_lane
            assign snap_addr_a[gi] = addr_snap_q[AW*gi +: AW];
            assign snap_data_a[gi] = data_snap_q[DW*gi +: DW];

            // Read data lands one cycle after its issue; the lane tag travels with it.
            always_comb begin
                q_d[DW*gi +: DW] = q_q[DW*gi +: DW];
                if (rd_vld_q && (rd_lane_q == LW'(gi)))
                    q_d[DW*gi +: DW] = mem_rdata;
            end
        end
    endgenerate

    always_comb begin
        lane_sel = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (pend_q[i]) lane_sel = LW'(i);
        end
        pend_clr = pend_q & ~(N_CORES'(1) << lane_sel);
    end

    assign start = (MRead | MWrite) & ~req_prev_q;

    always_comb begin
        state_d     = state_q;
        req_prev_d  = MRead | MWrite;
        wr_d        = wr_q;
        pend_d      = pend_q;
        addr_snap_d = addr_snap_q;
        data_snap_d = data_snap_q;
        rd_vld_d    = 1'b0;
        rd_lane_d   = rd_lane_q;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        MReady      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // A simultaneous read+write is a write.
                    wr_d        = MWrite;
                    pend_d      = en;
                    addr_snap_d = addr;
                    data_snap_d = data;
                    state_d     = (en == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                mem_addr  = snap_addr_a[lane_sel];
                mem_we    = wr_q;
                mem_re    = ~wr_q;
                mem_wdata = wr_q ? snap_data_a[lane_sel] : '0;
                pend_d    = pend_clr;
                rd_vld_d  = ~wr_q;
                rd_lane_d = lane_sel;
                if (pend_clr == '0)
                    state_d = wr_q ? DONE : DRAIN;
            end
            DRAIN: state_d = DONE;
            DONE: begin
                MReady  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_prev_q  <= 1'b0;
            wr_q        <= 1'b0;
            pend_q      <= '0;
            addr_snap_q <= '0;
            data_snap_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_lane_q   <= '0;
            q_q         <= '0;
        end else begin
            state_q     <= state_d;
            req_prev_q  <= req_prev_d;
            wr_q        <= wr_d;
            pend_q      <= pend_d;
            addr_snap_q <= addr_snap_d;
            data_snap_q <= data_snap_d;
            rd_vld_q    <= rd_vld_d;
            rd_lane_q   <= rd_lane_d;
            q_q         <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_n_mem_arbiter.sv
// Directed plus randomized checks of n_mem_arbiter against a warp-level memory model.
module tb_n_mem_arbiter;

    localparam int N  = 8;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              MRead, MWrite;
    logic [N-1:0]      en;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   data;
    logic [N*DW-1:0]   q;
    logic              MReady;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we, mem_re;
    logic [DW-1:0]     mem_rdata;

    n_mem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .MRead(MRead), .MWrite(MWrite), .en(en),
        .addr(addr), .data(data), .q(q), .MReady(MReady), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Device memory seen by the DUT; returns junk when no read was issued.
    logic [DW-1:0] dev_mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) dev_mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= dev_mem[mem_addr];
        else        mem_rdata <= DW'($urandom);
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:65535];
    logic [DW-1:0] q_exp [N];
    logic [AW-1:0] t_addr [N];
    logic [DW-1:0] t_data [N];
    int            exp_lane [$];
    logic          exp_wr;
    int            exp_ready;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [N-1:0] e);
        MRead  = rd;
        MWrite = wr;
        en     = e;
        for (int k = 0; k < N; k++) begin
            addr[AW*k +: AW] = t_addr[k];
            data[DW*k +: DW] = t_data[k];
        end
        exp_wr = wr;
        exp_lane.delete();
        for (int k = 0; k < N; k++) if (e[k]) exp_lane.push_back(k);
        if (exp_lane.size() == 0) exp_ready = 1;
        else exp_ready = exp_lane.size() + (wr ? 1 : 2);
        foreach (exp_lane[i]) begin
            if (wr) ref_mem[t_addr[exp_lane[i]]] = t_data[exp_lane[i]];
            else    q_exp[exp_lane[i]] = ref_mem[t_addr[exp_lane[i]]];
        end
    endtask

    // Called at the start of cycle 0 (request just driven).
    task automatic run_access(input string name, input int hold);
        int kk;
        kk = exp_lane.size();
        for (int c = 0; c <= exp_ready + hold + 2; c++) begin
            logic issuing;
            @(negedge clk);
            issuing = (c >= 1) && (c <= kk);
            chk($sformatf("%s c%0d mem_we", name, c), {31'b0, mem_we}, {31'b0, issuing && exp_wr});
            chk($sformatf("%s c%0d mem_re", name, c), {31'b0, mem_re}, {31'b0, issuing && !exp_wr});
            if (issuing) begin
                chk($sformatf("%s c%0d mem_addr", name, c), {16'b0, mem_addr}, {16'b0, t_addr[exp_lane[c-1]]});
                if (exp_wr)
                    chk($sformatf("%s c%0d mem_wdata", name, c), {16'b0, mem_wdata}, {16'b0, t_data[exp_lane[c-1]]});
            end
            chk($sformatf("%s c%0d MReady", name, c), {31'b0, MReady}, {31'b0, c == exp_ready});
            if (c == exp_ready)
                for (int k = 0; k < N; k++)
                    chk($sformatf("%s q[%0d]", name, k), {16'b0, q[DW*k +: DW]}, {16'b0, q_exp[k]});
            @(posedge clk);
            #1;
            if (c == 0) begin
                en   = N'($urandom);
                addr = {$urandom, $urandom, $urandom, $urandom};
                data = {$urandom, $urandom, $urandom, $urandom};
            end
            if (c == exp_ready + hold) begin
                MRead  = 1'b0;
                MWrite = 1'b0;
            end
        end
        if (exp_wr)
            foreach (exp_lane[i])
                chk($sformatf("%s mem[%0h]", name, t_addr[exp_lane[i]]),
                    {16'b0, dev_mem[t_addr[exp_lane[i]]]}, {16'b0, ref_mem[t_addr[exp_lane[i]]]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = '0;
            ref_mem[i] = '0;
        end
        for (int k = 0; k < N; k++) q_exp[k] = '0;
        reset = 1'b0; MRead = 1'b0; MWrite = 1'b0; en = '0; addr = '0; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset q", q[31:0], 32'h0);
        chk("reset MReady", {31'b0, MReady}, 32'h0);
        chk("reset strobes", {30'b0, mem_we, mem_re}, 32'h0);
        chk("reset mem_addr", {16'b0, mem_addr}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Full-warp write, then read-back
        for (int k = 0; k < N; k++) begin
            t_addr[k] = AW'(16'h10 + k);
            t_data[k] = DW'(16'hA000 + k);
        end
        drive_req(1'b0, 1'b1, 8'hFF);
        run_access("wr_full", 0);
        drive_req(1'b1, 1'b0, 8'hFF);
        run_access("rd_full", 0);

        // Sparse read over fresh data
        for (int k = 0; k < N; k++) begin
            t_addr[k] = AW'(16'h10 + ((k + 3) % N));
            t_data[k] = '0;
        end
        drive_req(1'b1, 1'b0, 8'b1010_0100);
        run_access("rd_sparse", 0);

        // No lanes enabled, request held long afterwards
        drive_req(1'b1, 1'b0, 8'h00);
        run_access("rd_none_hold", 20);

        // Read+write together acts as a write
        t_addr[0] = 16'h0030;
        t_data[0] = 16'h5555;
        drive_req(1'b1, 1'b1, 8'h01);
        run_access("rdwr", 0);

        // Randomized warps with colliding addresses
        for (int t = 0; t < 30; t++) begin
            int op;
            logic [N-1:0] e;
            op = int'($urandom_range(0, 2));
            e  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            for (int k = 0; k < N; k++) begin
                t_addr[k] = AW'($urandom_range(0, 15));
                t_data[k] = DW'($urandom);
            end
            drive_req(op != 1, op != 0, e);
            run_access($sformatf("rnd%0d", t), 0);
        end

        // Reset in the middle of a full read
        for (int k = 0; k < N; k++) t_addr[k] = AW'(16'h10 + k);
        drive_req(1'b1, 1'b0, 8'hFF);
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) q_exp[k] = '0;
        chk("abort q", q[63:32], 32'h0);
        chk("abort q_lo", q[31:0], 32'h0);
        chk("abort MReady", {31'b0, MReady}, 32'h0);
        chk("abort strobes", {30'b0, mem_we, mem_re}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        drive_req(1'b1, 1'b0, 8'hFF);
        run_access("post_reset_rd", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/n_mem_arbiter.md
Name: n_mem_arbiter

Overview:
- Sits directly downstream of the N-core SP array.
- Collects the per-core memory requests (addr/data per lane, broadcast MRead/MWrite, per-lane en) and serializes them onto one single-ported synchronous data memory.
- Returns per-lane read data and a one-cycle MReady pulse to the cores/SM controller when the whole warp access is complete.

Parameters:
- N_CORES, 8, number of SP lanes
- AW, 16, address width per lane
- DW, 16, data width per lane

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- MRead  in  1  warp load request (level; held by controller until MReady)
- MWrite  in  1  warp store request (level; held until MReady)
- en  in  N_CORES  per-lane enable; only enabled lanes access memory
- addr  in  N_CORES*AW  lane k address at bits [AW*k+AW-1 : AW*k]
- data  in  N_CORES*DW  lane k store data, same packing
- q  out  N_CORES*DW  lane k load result, same packing
- MReady  out  1  one-cycle pulse: warp access complete
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  DW  read data, valid exactly one cycle after the mem_re cycle

Behaviour:
- Reset (reset=0, async): state=IDLE; q=0 all lanes; MReady=0; mem_we=0; mem_re=0; mem_addr=0; mem_wdata=0; req_prev=0; snapshot registers cleared.
- Request detect: start = (MRead|MWrite) & ~req_prev. req_prev is a register of (MRead|MWrite). Only a rising edge starts an access, so a request held high after MReady never retriggers. start is ignored outside IDLE.
- MRead & MWrite both high at start: treated as a write; the read is dropped.
- IDLE: on start, snapshot en, addr, data and the op into registers; go to ISSUE. If the snapshot en=0, go to DONE instead.
- Later changes to en, addr or data have no effect on an access in progress.
- ISSUE: each cycle serves the lowest-index remaining enabled lane k.
  - mem_addr = addr[k]; mem_re or mem_we = 1; for writes, mem_wdata = data[k].
  - Clear lane k from the pending mask. When the mask becomes empty: reads go to DRAIN, writes go to DONE.
  - Exactly one memory access per cycle, no bubbles between lanes.
- Read capture (pipelined): lane index is delayed one cycle alongside mem_re. At the next edge, q[k] <= mem_rdata. Capture also happens in DRAIN for the last lane.
- DRAIN: one cycle to capture the last read; then DONE.
- DONE: MReady=1 for exactly one cycle; next state IDLE.
- mem_re and mem_we are 0 in IDLE, DRAIN and DONE.
- q holding rules: q of disabled lanes holds its prior value; writes never modify q.
- Latency (cycle 0 = cycle in which the rising edge of the request is visible, K = popcount(en)):
  - Issues occupy cycles 1..K.
  - Write: MReady in cycle K+1.
  - Read: all q valid and MReady in cycle K+2.
  - K=0: MReady in cycle 1, no memory access.
- Duplicate addresses across lanes are issued separately, in lane order. Later writes win; reads each return memory contents.
- Reset mid-access: access is aborted immediately; outputs return to reset values. A request still held high after reset release starts a new access (req_prev=0).

Test Plan:
- Reset then write, N=8, en=8'hFF, addr[k]=0x10+k, data[k]=0xA000+k -> mem_we in cycles 1..8 with addr 0x10..0x17 in order; MReady single pulse in cycle 9; memory model holds 0xA000..0xA007.
- Read-back of the same, en=8'hFF -> mem_re in cycles 1..8; q[k]=0xA000+k; MReady in cycle 10 only.
- Sparse read, en=8'b1010_0100 -> exactly 3 reads (lanes 2,5,7, in order); MReady in cycle 5; q of lanes 0,1,3,4,6 unchanged.
- en=0 with MRead -> no mem_re/mem_we; MReady in cycle 1. Then hold MRead high 20 more cycles -> no second MReady.
- MRead&MWrite together, en=8'h01, addr 0x30, data 0x5555 -> one write only; q unchanged; MReady in cycle 2.
- Assert reset=0 during cycle 4 of an 8-lane read -> q=0, MReady=0, strobes 0 immediately. Release reset with MRead still high -> fresh access; MReady in cycle 10 relative to the first cycle after release.
